// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Decodes load/store size and address into byte lanes, flags misaligned accesses,
// runs a req/ack handshake to data memory with a timeout, stalls the pipeline while
// the access is outstanding, and hands the raw read word plus lane select downstream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_en_i, mem_we_i  MEM-stage load/store valid, 1 = store
//   size_i              00 byte, 01 half, 10 word, 11 reserved (no access)
//   addr_i, wdata_i     effective byte address, right-justified store data
//   flush_i             squash MEM-stage instr (only blocks a new start)
//   stall_o, done_o     hold IF..MEM; 1-cycle completion pulse
//   ls_sel_o, rdata_o   lane select and raw read word for the extractor
//   adel_o, ades_o      misaligned load/store; badvaddr_o holds the faulting address
//   bus_err_o           ack timeout, valid with done_o
//   dm_*                data-memory request interface (little-endian lanes)
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_i,
  input  logic        mem_we_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [3:0]  ls_sel_o,
  output logic [31:0] rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic [31:0] badvaddr_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  ls_sel_q, ls_sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;

  logic [3:0]  lane_be;
  logic [31:0] wdata_rep;
  logic        misaligned;
  logic        reserved;

  // Lane decode and store-data replication.
  always_comb begin
    lane_be   = 4'b0000;
    wdata_rep = wdata_i;
    unique case (size_i)
      2'b00: begin
        lane_be   = 4'b0001 << addr_i[1:0];
        wdata_rep = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        lane_be   = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        lane_be   = 4'b1111;
        wdata_rep = wdata_i;
      end
      default: begin
        lane_be   = 4'b0000;
        wdata_rep = wdata_i;
      end
    endcase
  end

  assign misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                      ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
  assign reserved   = (size_i == 2'b11);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_be_d    = dm_be_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    ls_sel_d   = ls_sel_q;
    rdata_d    = rdata_q;
    bus_err_d  = bus_err_q;
    stall_o    = 1'b0;
    adel_o     = 1'b0;
    ades_o     = 1'b0;
    badvaddr_o = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (mem_en_i && !flush_i) begin
          if (misaligned) begin
            // Exception path: report only, no stall and no memory request.
            adel_o     = !mem_we_i;
            ades_o     = mem_we_i;
            badvaddr_o = addr_i;
          end else if (reserved) begin
            ls_sel_d = 4'b0000;
          end else begin
            stall_o    = 1'b1;
            dm_req_d   = 1'b1;
            dm_we_d    = mem_we_i;
            dm_be_d    = lane_be;
            dm_addr_d  = {addr_i[31:2], 2'b00};
            dm_wdata_d = wdata_rep;
            ls_sel_d   = lane_be;
            cnt_d      = 8'd0;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        // flush_i is deliberately ignored: a started access always completes.
        stall_o = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (dm_ack_i) begin
          dm_req_d = 1'b0;
          rdata_d  = dm_we_q ? 32'h0 : dm_rdata_i;
          state_d  = StDone;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          dm_req_d  = 1'b0;
          rdata_d   = 32'h0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        cnt_d     = 8'd0;
        bus_err_d = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_be_q    <= 4'b0000;
      dm_addr_q  <= 32'h0;
      dm_wdata_q <= 32'h0;
      ls_sel_q   <= 4'b0000;
      rdata_q    <= 32'h0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_be_q    <= dm_be_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      ls_sel_q   <= ls_sel_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign done_o     = (state_q == StDone);
  assign dm_req_o   = dm_req_q;
  assign dm_we_o    = dm_we_q;
  assign dm_be_o    = dm_be_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_wdata_o = dm_wdata_q;
  assign ls_sel_o   = ls_sel_q;
  assign rdata_o    = rdata_q;
  assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: table of load/store vectors plus hand sequences for
// flush and mid-access reset. Completion results go through a scoreboard queue that a
// done_o monitor drains.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_i, mem_we_i, flush_i, dm_ack_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i, dm_rdata_i;
  logic        stall_o, done_o, adel_o, ades_o, bus_err_o, dm_req_o, dm_we_o;
  logic [3:0]  ls_sel_o, dm_be_o;
  logic [31:0] rdata_o, badvaddr_o, dm_addr_o, dm_wdata_o;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_en_i   (mem_en_i),
    .mem_we_i   (mem_we_i),
    .size_i     (size_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .ls_sel_o   (ls_sel_o),
    .rdata_o    (rdata_o),
    .adel_o     (adel_o),
    .ades_o     (ades_o),
    .bus_err_o  (bus_err_o),
    .badvaddr_o (badvaddr_o),
    .dm_req_o   (dm_req_o),
    .dm_we_o    (dm_we_o),
    .dm_be_o    (dm_be_o),
    .dm_addr_o  (dm_addr_o),
    .dm_wdata_o (dm_wdata_o),
    .dm_ack_i   (dm_ack_i),
    .dm_rdata_i (dm_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          ack_lat;   // REQ cycle index carrying the ack; -1 = never
    logic        flush_req; // hold flush_i high while in REQ
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_adel;
    logic        e_ades;
    logic        e_bus;
  } vec_t;

  typedef struct {
    logic [3:0]  ls_sel;
    logic [31:0] rdata;
    logic        bus_err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard drain: every done_o pulse must match the oldest outstanding access.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected_done: got done_o=1 want no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ls_sel", 32'(ls_sel_o), 32'(e.ls_sel));
        chk("sb_rdata", rdata_o, e.rdata);
        chk("sb_bus_err", 32'(bus_err_o), 32'(e.bus_err));
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int req_cyc;
    int stall_cyc;
    bit got;
    @(negedge clk);
    mem_en_i = 1'b1;
    mem_we_i = v.we;
    size_i   = v.size;
    addr_i   = v.addr;
    wdata_i  = v.wdata;
    flush_i  = 1'b0;
    dm_rdata_i = v.mrdata;
    #1;
    if (v.e_adel || v.e_ades) begin
      chk($sformatf("v%0d_adel", idx), 32'(adel_o), 32'(v.e_adel));
      chk($sformatf("v%0d_ades", idx), 32'(ades_o), 32'(v.e_ades));
      chk($sformatf("v%0d_badvaddr", idx), badvaddr_o, v.addr);
      chk($sformatf("v%0d_err_stall", idx), 32'(stall_o), 32'd0);
      @(negedge clk);
      mem_en_i = 1'b0;
      chk($sformatf("v%0d_err_noreq", idx), 32'(dm_req_o), 32'd0);
      return;
    end
    if (v.size == 2'b11) begin
      chk($sformatf("v%0d_rsv_stall", idx), 32'(stall_o), 32'd0);
      @(negedge clk);
      mem_en_i = 1'b0;
      chk($sformatf("v%0d_rsv_noreq", idx), 32'(dm_req_o), 32'd0);
      chk($sformatf("v%0d_rsv_ls_sel", idx), 32'(ls_sel_o), 32'd0);
      chk($sformatf("v%0d_rsv_done", idx), 32'(done_o), 32'd0);
      return;
    end
    chk($sformatf("v%0d_start_stall", idx), 32'(stall_o), 32'd1);
    exp_q.push_back('{ls_sel: v.e_be, rdata: v.e_rdata, bus_err: v.e_bus});
    stall_cyc = 1;
    req_cyc   = 0;
    got       = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        dm_ack_i = 1'b0;
        flush_i  = 1'b0;
        mem_en_i = 1'b0;
        chk($sformatf("v%0d_done_stall", idx), 32'(stall_o), 32'd0);
      end else begin
        if (k == 0) begin
          chk($sformatf("v%0d_dm_addr", idx), dm_addr_o, v.addr & 32'hFFFF_FFFC);
          chk($sformatf("v%0d_dm_be", idx), 32'(dm_be_o), 32'(v.e_be));
          chk($sformatf("v%0d_dm_we", idx), 32'(dm_we_o), 32'(v.we));
          chk($sformatf("v%0d_dm_wdata", idx), dm_wdata_o, v.e_wdata);
          chk($sformatf("v%0d_req_noerr", idx), 32'({adel_o, ades_o}), 32'd0);
        end
        if (dm_req_o) req_cyc++;
        if (stall_o) stall_cyc++;
        flush_i  = v.flush_req;
        dm_ack_i = (v.ack_lat >= 0) && (k == v.ack_lat);
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d_timeout_wait: got no done_o want done_o within 64 cycles", idx);
      return;
    end
    chk($sformatf("v%0d_req_cycles", idx), 32'(req_cyc),
        (v.ack_lat < 0) ? 32'd8 : 32'(v.ack_lat + 1));
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_cyc),
        (v.ack_lat < 0) ? 32'd9 : 32'(v.ack_lat + 2));
    @(negedge clk);
    chk($sformatf("v%0d_idle_done", idx), 32'(done_o), 32'd0);
    chk($sformatf("v%0d_idle_bus_err", idx), 32'(bus_err_o), 32'd0);
    chk($sformatf("v%0d_hold_ls_sel", idx), 32'(ls_sel_o), 32'(v.e_be));
    chk($sformatf("v%0d_hold_rdata", idx), rdata_o, v.e_rdata);
  endtask

  initial begin
    //           we size   addr      wdata         mrdata        lat fl be       e_wdata       e_rdata      adel ades bus
    vecs[0]  = '{0, 2'b00, 32'h1003, 32'h12,       32'hAABBCCDD, 0,  0, 4'b1000, 32'h12121212, 32'hAABBCCDD, 0, 0, 0};
    vecs[1]  = '{1, 2'b01, 32'h2002, 32'h0000ABCD, 32'h55555555, 1,  0, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 0};
    vecs[2]  = '{0, 2'b10, 32'h1002, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1, 0, 0};
    vecs[3]  = '{1, 2'b10, 32'h1001, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        0, 1, 0};
    vecs[4]  = '{0, 2'b01, 32'h3000, 32'hDEADBEEF, 32'h11223344, 2,  1, 4'b0011, 32'hBEEFBEEF, 32'h11223344, 0, 0, 0};
    vecs[5]  = '{1, 2'b10, 32'h4004, 32'hCAFEF00D, 32'h99999999, 0,  0, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0, 0};
    vecs[6]  = '{0, 2'b00, 32'h5001, 32'hA5,       32'h01020304, 3,  0, 4'b0010, 32'hA5A5A5A5, 32'h01020304, 0, 0, 0};
    vecs[7]  = '{1, 2'b00, 32'h5002, 32'h3C,       32'h77777777, 0,  0, 4'b0100, 32'h3C3C3C3C, 32'h0,        0, 0, 0};
    vecs[8]  = '{0, 2'b10, 32'h6000, 32'h0,        32'hFFFFFFFF, -1, 0, 4'b1111, 32'h0,        32'h0,        0, 0, 1};
    vecs[9]  = '{0, 2'b11, 32'h7000, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        0, 0, 0};
    vecs[10] = '{1, 2'b01, 32'h2001, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        0, 1, 0};
    vecs[11] = '{0, 2'b01, 32'h2003, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1, 0, 0};

    rst = 1'b1;
    mem_en_i = 1'b0; mem_we_i = 1'b0; size_i = 2'b00; addr_i = 32'h0; wdata_i = 32'h0;
    flush_i = 1'b0; dm_ack_i = 1'b0; dm_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_dm_req", 32'(dm_req_o), 32'd0);
    chk("rst_ls_sel", 32'(ls_sel_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    chk("rst_dm_be", 32'(dm_be_o), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Flush in IDLE: aligned and misaligned both suppressed.
    @(negedge clk);
    mem_en_i = 1'b1; mem_we_i = 1'b0; size_i = 2'b10; addr_i = 32'h8000; flush_i = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_o), 32'd0);
    addr_i = 32'h8001;
    #1;
    chk("flush_no_adel", 32'(adel_o), 32'd0);
    @(negedge clk);
    chk("flush_no_req", 32'(dm_req_o), 32'd0);
    mem_en_i = 1'b0; flush_i = 1'b0;

    // Reset during the second REQ cycle; a later ack must be ignored.
    @(negedge clk);
    mem_en_i = 1'b1; mem_we_i = 1'b0; size_i = 2'b10; addr_i = 32'h9000;
    @(negedge clk);
    chk("rstreq_req1", 32'(dm_req_o), 32'd1);
    @(negedge clk);
    chk("rstreq_req2", 32'(dm_req_o), 32'd1);
    rst = 1'b1; mem_en_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstreq_dm_req", 32'(dm_req_o), 32'd0);
    chk("rstreq_stall", 32'(stall_o), 32'd0);
    dm_ack_i = 1'b1;
    @(negedge clk);
    chk("rstreq_ack_done", 32'(done_o), 32'd0);
    chk("rstreq_ack_req", 32'(dm_req_o), 32'd0);
    @(negedge clk);
    dm_ack_i = 1'b0;
    chk("rstreq_ack_done2", 32'(done_o), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
